// File: rtl/decode_fetch_queue.sv
// Fetch-to-decode decoupling queue: a DEPTH-entry circular buffer feeding one
// registered decode slot, with same-cycle bypass, flush and pre-decoded register fields.
module decode_fetch_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int PRED_WIDTH  = 1,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    input  logic [PRED_WIDTH-1:0]        in_pred,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [INSTR_WIDTH-1:0]       out_instr,
    output logic [PRED_WIDTH-1:0]        out_pred,
    output logic [4:0]                   out_rs1_addr,
    output logic [4:0]                   out_rs2_addr,
    output logic [4:0]                   out_rd_addr,
    output logic [$clog2(DEPTH+2)-1:0]   count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(DEPTH + 2);
    localparam logic [QCNT_W-1:0] DEPTH_Q  = QCNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [PRED_WIDTH-1:0]  pred_mem_q  [DEPTH];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [QCNT_W-1:0]      qcount_q, qcount_d;
    logic                   out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [PRED_WIDTH-1:0]  out_pred_q, out_pred_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic in_fire, out_fire, slot_load, q_empty, deq, bypass, enq;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready looks only at registered occupancy and flush, never at the decode side.
    assign in_ready  = (qcount_q < DEPTH_Q) & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign slot_load = ~out_valid_q | out_fire;
    assign q_empty   = (qcount_q == '0);
    assign deq       = slot_load & ~q_empty;
    assign bypass    = slot_load & q_empty & in_fire;
    assign enq       = in_fire & ~bypass;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        qcount_d    = qcount_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_pred_d  = out_pred_q;
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            qcount_d    = '0;
            out_valid_d = 1'b0;
            out_pc_d    = '0;
            out_instr_d = '0;
            out_pred_d  = '0;
        end else begin
            if (slot_load) begin
                if (!q_empty) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_mem_q[head_q];
                    out_instr_d = instr_mem_q[head_q];
                    out_pred_d  = pred_mem_q[head_q];
                end else if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = in_pc;
                    out_instr_d = in_instr;
                    out_pred_d  = in_pred;
                end else begin
                    out_valid_d = 1'b0;
                    out_pc_d    = '0;
                    out_instr_d = '0;
                    out_pred_d  = '0;
                end
            end
            if (enq) tail_d = ptr_next(tail_q);
            if (deq) head_d = ptr_next(head_q);
            case ({enq, deq})
                2'b10:   qcount_d = qcount_q + QCNT_W'(1);
                2'b01:   qcount_d = qcount_q - QCNT_W'(1);
                default: qcount_d = qcount_q;
            endcase
        end
        count_d = CNT_W'(qcount_d) + CNT_W'(out_valid_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            qcount_q    <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_pred_q  <= '0;
            count_q     <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            qcount_q    <= qcount_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_pred_q  <= out_pred_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: occupancy and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
            pred_mem_q[tail_q]  <= in_pred;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign out_pred     = out_pred_q;
    assign out_rs1_addr = out_instr_q[19:15];
    assign out_rs2_addr = out_instr_q[24:20];
    assign out_rd_addr  = out_instr_q[11:7];
    assign count        = count_q;

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Randomised bench for decode_fetch_queue: an ordered list of held packets
// (decode slot first) predicts every output and ready value.
module tb_decode_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } pkt_t;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic        in_pred, out_pred;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    pkt_t model[$];
    logic dutReady, expReady, lastAccepted, lastOutFire;
    logic [31:0] lastOutPc;

    wire [68:0] dutVec  = {out_valid, out_pc, out_instr, out_pred, count};
    wire [14:0] dutRegs = {out_rs1_addr, out_rs2_addr, out_rd_addr};

    decode_fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .PRED_WIDTH(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_pred(out_pred),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [68:0] expVec();
        if (model.size() == 0) return 69'd0;
        return {1'b1, model[0].pc, model[0].instr, model[0].pred, 3'(model.size())};
    endfunction

    function automatic logic [14:0] expRegs();
        logic [31:0] ins;
        if (model.size() == 0) return 15'd0;
        ins = model[0].instr;
        return {ins[19:15], ins[24:20], ins[11:7]};
    endfunction

    // One clock: drive inputs, sample pre-edge values, advance the model, settle.
    task automatic tick(input logic fl, input logic iv, input logic orr,
                        input logic [31:0] pc, input logic [31:0] ins, input logic pr);
        pkt_t p;
        int queued;
        flush = fl; in_valid = iv; out_ready = orr;
        in_pc = pc; in_instr = ins; in_pred = pr;
        #1;
        dutReady    = in_ready;
        queued      = (model.size() > 0) ? model.size() - 1 : 0;
        expReady    = (queued < DEPTH) && !fl;
        lastOutFire = out_valid & orr;
        lastOutPc   = out_pc;
        lastAccepted = iv && expReady;
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (model.size() > 0 && orr) void'(model.pop_front());
            if (lastAccepted) begin
                p.pc = pc; p.instr = ins; p.pred = pr;
                model.push_back(p);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h12345678;
        in_pred = 1'b1; flush = 1'b0; out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (dutVec !== 69'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs got %h exp 0", dutVec);
            end
        end
        rst = 1'b0; in_valid = 1'b0; model.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready);
        end
        repeat (3) begin
            tick(0, 0, 1, 0, 0, 0);
            checks++;
            if (dutVec !== 69'd0) begin
                errors++;
                $display("[TB] FAIL reset_idle got %h exp 0", dutVec);
            end
        end
    endtask

    task automatic test_bypass();
        tick(0, 1, 1, 32'h100, 32'h00208033, 1'b0);
        checks++;
        if (dutVec !== expVec() || out_pc !== 32'h100 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL bypass_out got %h exp %h", dutVec, expVec());
        end
        checks++;
        if (dutRegs !== {5'd1, 5'd2, 5'd0}) begin
            errors++;
            $display("[TB] FAIL bypass_regs got %h exp %h", dutRegs, {5'd1, 5'd2, 5'd0});
        end
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bypass_drain got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_fill_drain();
        int accepted = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0, 1, 0, 32'(4 * i), $urandom(), 1'($urandom_range(0, 1)));
            if (dutReady) accepted++;
            checks++;
            if (dutReady !== expReady || dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL fill_step%0d got rdy=%b %h exp rdy=%b %h",
                         i, dutReady, dutVec, expReady, expVec());
            end
        end
        checks++;
        if (accepted != 5 || count !== 3'd5 || out_pc !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full got acc=%0d c=%0d pc=%h rdy=%b exp acc=5 c=5 pc=0 rdy=0",
                     accepted, count, out_pc, in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 1, 0, 0, 0);
            checks++;
            if (lastOutPc !== 32'(4 * k) || dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL drain_pc%0d got %h exp %h", k, lastOutPc, 32'(4 * k));
            end
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL drain_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 32'(32'h20 + 4 * i), $urandom(), 1'b0);
        checks++;
        if (count !== 3'd5) begin
            errors++;
            $display("[TB] FAIL flush_prefill got %0d exp 5", count);
        end
        tick(1, 1, 0, 32'h80, $urandom(), 1'b1);
        checks++;
        if (dutReady !== 1'b0 || dutVec !== 69'd0 || dutRegs !== 15'd0) begin
            errors++;
            $display("[TB] FAIL flush_clear got rdy=%b %h exp rdy=0 0", dutReady, dutVec);
        end
        tick(0, 1, 1, 32'h200, 32'h00a00093, 1'b0);
        checks++;
        if (dutReady !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h200 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL flush_resume got rdy=%b v=%b pc=%h exp rdy=1 v=1 pc=200",
                     dutReady, out_valid, out_pc);
        end
        tick(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_stream();
        int nextIdx = 0;
        int cyc = 0;
        logic [31:0] seen[$];
        logic iv, orr;
        while ((nextIdx < 20 || model.size() > 0) && cyc < 400) begin
            orr = (cyc % 4 == 0) || (cyc % 4 == 3);
            iv  = (nextIdx < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(0, iv, orr, 32'(4 * nextIdx), $urandom(), 1'($urandom_range(0, 1)));
            if (lastOutFire) seen.push_back(lastOutPc);
            if (lastAccepted) nextIdx++;
            checks++;
            if (dutReady !== expReady || dutVec !== expVec() || dutRegs !== expRegs() || count > 3'd5) begin
                errors++;
                $display("[TB] FAIL stream_cyc%0d got rdy=%b %h exp rdy=%b %h",
                         cyc, dutReady, dutVec, expReady, expVec());
            end
            cyc++;
        end
        checks++;
        if (cyc >= 400 || seen.size() != 20) begin
            errors++;
            $display("[TB] FAIL stream_len got %0d outputs in %0d cycles exp 20", seen.size(), cyc);
        end
        for (int k = 0; k < seen.size() && k < 20; k++) begin
            checks++;
            if (seen[k] !== 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL stream_order%0d got %h exp %h", k, seen[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        logic [64:0] snap;
        tick(0, 1, 0, 32'h300, $urandom(), 1'b1);
        snap = {out_pc, out_instr, out_pred};
        checks++;
        if (out_pc !== 32'h300 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL stall_load got pc=%h c=%0d exp pc=300 c=1", out_pc, count);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, (i < 2), 0, 32'(32'h304 + 4 * i), $urandom(), 1'b0);
            checks++;
            if ({out_pc, out_instr, out_pred} !== snap || count !== 3'((i < 2) ? i + 2 : 3)) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got %h c=%0d exp %h c=%0d",
                         i, {out_pc, out_instr, out_pred}, count, snap, (i < 2) ? i + 2 : 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL stall_drain%0d got %h exp %h", i, dutVec, expVec());
            end
        end
    endtask

    task automatic test_random_flush();
        for (int c = 0; c < 200; c++) begin
            tick(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            checks++;
            if (dutReady !== expReady || dutVec !== expVec() || dutRegs !== expRegs()) begin
                errors++;
                $display("[TB] FAIL random_cyc%0d got rdy=%b %h exp rdy=%b %h",
                         c, dutReady, dutVec, expReady, expVec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 32'(32'h500 + 4 * i), $urandom(), 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (dutVec !== 69'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid got %h exp 0", dutVec);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model.delete();
        tick(0, 1, 1, 32'h44, 32'h00c58533, 1'b0);
        checks++;
        if (out_pc !== 32'h44 || count !== 3'd1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL reset_mid_resume got pc=%h c=%0d exp pc=44 c=1", out_pc, count);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_pred = 1'b0;
        test_reset();
        test_bypass();
        test_fill_drain();
        test_flush();
        test_stream();
        test_stall();
        test_random_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
